// File: rtl/cpu_wb_arb_pkg.sv
// Shared constants and the pending-result record for the CPU writeback arbiter.
package cpu_wb_arb_pkg;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREG  = 1 << AW;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } wb_entry_t;
endpackage

// File: rtl/cpu_wb_arb_fifo.sv
// In-order pending-result FIFO; entry 0 is always the head. Each entry (and the
// entry being pushed) is squashed when a younger pipeline write targets its address.
module cpu_wb_arb_fifo
    import cpu_wb_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    input  logic          flush,
    input  logic          inv_en,
    input  logic [AW-1:0] inv_addr,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          inv_hit
);
    wb_entry_t     ent_q [DEPTH];
    wb_entry_t     ent_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] wr_idx;
    wb_entry_t     pe;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        inv_hit = 1'b0;
        pe      = push_entry;
        wr_idx  = count_q - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            if (inv_en && ent_q[i].valid && ent_q[i].waddr == inv_addr) begin
                ent_d[i].valid = 1'b0;
                inv_hit        = 1'b1;
            end
        end
        if (inv_en && push && pe.valid && pe.waddr == inv_addr) begin
            pe.valid = 1'b0;
            inv_hit  = 1'b1;
        end
        // Slots beyond the occupancy are kept zeroed so they never match.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_d[i+1];
            ent_d[DEPTH-1] = '0;
        end
        if (push) ent_d[wr_idx[IW-1:0]] = pe;
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

    assign head  = ent_q[0];
    assign count = count_q;
endmodule

// File: rtl/cpu_wb_arb.sv
// Register-file write port arbiter: pipeline writeback wins, multicycle results queue.
// Optional busy scoreboard enabled by defining CPU_WB_ARB_SCOREBOARD_EN.
module cpu_wb_arb
    import cpu_wb_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_rfw,
    input  logic [AW-1:0]   pipe_waddr,
    input  logic [DW-1:0]   pipe_wdata,
    input  logic            mc_valid,
    input  logic [AW-1:0]   mc_waddr,
    input  logic [DW-1:0]   mc_wdata,
    output logic            mc_ready,
    input  logic            flush,
    output logic            rfw,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   wdata,
    input  logic            mc_issue,
    input  logic [AW-1:0]   mc_issue_addr,
    output logic [NREG-1:0] busy
);
    logic          pipe_hit, push, pop, head_wr, inv_hit;
    wb_entry_t     push_entry, head;
    logic [CW-1:0] count;

    assign pipe_hit   = pipe_rfw && (pipe_waddr != '0);
    assign mc_ready   = (count < CW'(DEPTH)) && !flush;
    assign push       = mc_valid && mc_ready;
    assign push_entry = '{valid: (mc_waddr != '0), waddr: mc_waddr, wdata: mc_wdata};
    // A squashed head drains even while the pipeline owns the port.
    assign head_wr    = (count != '0) && head.valid && !pipe_hit && !flush;
    assign pop        = (count != '0) && (!head.valid || !pipe_hit);

    cpu_wb_arb_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .inv_en     (pipe_hit),
        .inv_addr   (pipe_waddr),
        .head       (head),
        .count      (count),
        .inv_hit    (inv_hit)
    );

    always_comb begin
        rfw      = 1'b0;
        rf_waddr = '0;
        wdata    = '0;
        if (pipe_hit) begin
            rfw      = 1'b1;
            rf_waddr = pipe_waddr;
            wdata    = pipe_wdata;
        end else if (head_wr) begin
            rfw      = 1'b1;
            rf_waddr = head.waddr;
            wdata    = head.wdata;
        end
    end

`ifdef CPU_WB_ARB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d, set_m, clr_m;

    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (mc_issue && mc_issue_addr != '0) set_m[mc_issue_addr] = 1'b1;
        if (flush) begin
            clr_m = '1;
        end else begin
            if (head_wr) clr_m[head.waddr]  = 1'b1;
            if (inv_hit) clr_m[pipe_waddr]  = 1'b1;
        end
        // Set is applied last so a same-cycle reissue keeps the bit.
        busy_d = (busy_q & ~clr_m) | set_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{mc_issue, mc_issue_addr};
    assign busy = '0;
`endif
endmodule

// File: tb/tb_cpu_wb_arb.sv
// Directed self-checking bench for cpu_wb_arb.
module tb_cpu_wb_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_rfw;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mc_valid;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        flush;
    logic        rfw;
    logic [4:0]  rf_waddr;
    logic [31:0] wdata;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    cpu_wb_arb dut (
        .clk(clk), .rst(rst),
        .pipe_rfw(pipe_rfw), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
        .flush(flush), .rfw(rfw), .rf_waddr(rf_waddr), .wdata(wdata),
        .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pipe_rfw = 0; pipe_waddr = 0; pipe_wdata = 0;
        mc_valid = 0; mc_waddr = 0; mc_wdata = 0;
        flush = 0; mc_issue = 0; mc_issue_addr = 0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_rfw = 1; pipe_waddr = a; pipe_wdata = d;
    endtask

    task automatic mc(input logic [4:0] a, input logic [31:0] d);
        mc_valid = 1; mc_waddr = a; mc_wdata = d;
    endtask

    task automatic test_reset;
        rst = 1; idle; #1;
        checks++;
        if (rfw !== 0 || rf_waddr !== 0 || wdata !== 0 || mc_ready !== 1 || busy !== 0) begin
            errors++; $display("FAIL reset_state got rfw=%b a=%0d d=%h rdy=%b busy=%h exp 0/0/0/1/0",
                               rfw, rf_waddr, wdata, mc_ready, busy);
        end
        pipe(5'd3, 32'h33); #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 3 || wdata !== 32'h33) begin
            errors++; $display("FAIL reset_pipe got %b/%0d/%h exp 1/3/33", rfw, rf_waddr, wdata);
        end
        idle; tick; tick;
        rst = 0; #1;
    endtask

    task automatic test_single;
        mc(5'd5, 32'h1234); #1;
        checks++;
        if (rfw !== 0 || mc_ready !== 1) begin
            errors++; $display("FAIL single_nobypass got rfw=%b rdy=%b exp 0/1", rfw, mc_ready);
        end
        tick; idle; #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 5 || wdata !== 32'h1234) begin
            errors++; $display("FAIL single_write got %b/%0d/%h exp 1/5/1234", rfw, rf_waddr, wdata);
        end
        tick;
        checks++;
        if (rfw !== 0 || rf_waddr !== 0 || wdata !== 0 || mc_ready !== 1) begin
            errors++; $display("FAIL single_empty got %b/%0d/%h rdy=%b exp 0/0/0 rdy=1",
                               rfw, rf_waddr, wdata, mc_ready);
        end
    endtask

    task automatic test_pipe_priority;
        pipe(5'd7, 32'h77); mc(5'd3, 32'h3); #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 7 || wdata !== 32'h77 || mc_ready !== 1) begin
            errors++; $display("FAIL prio_c0 got %b/%0d/%h rdy=%b exp 1/7/77 rdy=1", rfw, rf_waddr, wdata, mc_ready);
        end
        tick; mc(5'd4, 32'h4); #1;
        checks++;
        if (rf_waddr !== 7 || mc_ready !== 1) begin
            errors++; $display("FAIL prio_c1 got a=%0d rdy=%b exp 7/1", rf_waddr, mc_ready);
        end
        tick; mc_valid = 0; #1;
        checks++;
        if (rf_waddr !== 7 || wdata !== 32'h77 || mc_ready !== 0) begin
            errors++; $display("FAIL prio_full got a=%0d d=%h rdy=%b exp 7/77/0", rf_waddr, wdata, mc_ready);
        end
        tick; idle; #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 3 || wdata !== 32'h3 || mc_ready !== 0) begin
            errors++; $display("FAIL prio_r3 got %b/%0d/%h rdy=%b exp 1/3/3 rdy=0", rfw, rf_waddr, wdata, mc_ready);
        end
        tick;
        checks++;
        if (rfw !== 1 || rf_waddr !== 4 || wdata !== 32'h4 || mc_ready !== 1) begin
            errors++; $display("FAIL prio_r4 got %b/%0d/%h rdy=%b exp 1/4/4 rdy=1", rfw, rf_waddr, wdata, mc_ready);
        end
        tick;
        checks++;
        if (rfw !== 0) begin
            errors++; $display("FAIL prio_done got rfw=%b exp 0", rfw);
        end
    endtask

    task automatic test_waw;
        mc(5'd9, 32'h9999); tick; idle;
        pipe(5'd9, 32'hAAAA); #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 9 || wdata !== 32'hAAAA) begin
            errors++; $display("FAIL waw_pipe got %b/%0d/%h exp 1/9/aaaa", rfw, rf_waddr, wdata);
        end
        tick; idle; #1;
        checks++;
        if (rfw !== 0) begin
            errors++; $display("FAIL waw_dropped got rfw=%b a=%0d exp 0", rfw, rf_waddr);
        end
        pipe(5'd10, 32'hB0); mc(5'd10, 32'hC0); tick; idle; #1;
        checks++;
        if (rfw !== 0) begin
            errors++; $display("FAIL waw_push_squash got rfw=%b a=%0d exp 0", rfw, rf_waddr);
        end
        tick;
    endtask

    task automatic test_r0;
        mc(5'd0, 32'h5); #1;
        checks++;
        if (rfw !== 0) begin
            errors++; $display("FAIL r0_push got rfw=%b exp 0", rfw);
        end
        tick; mc(5'd11, 32'hB); #1;
        checks++;
        if (rfw !== 0 || rf_waddr !== 0 || wdata !== 0 || mc_ready !== 1) begin
            errors++; $display("FAIL r0_pop got %b/%0d/%h rdy=%b exp 0/0/0 rdy=1", rfw, rf_waddr, wdata, mc_ready);
        end
        tick; idle; #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 11 || wdata !== 32'hB) begin
            errors++; $display("FAIL r0_next got %b/%0d/%h exp 1/11/b", rfw, rf_waddr, wdata);
        end
        tick; pipe(5'd0, 32'hDEAD); #1;
        checks++;
        if (rfw !== 0) begin
            errors++; $display("FAIL r0_pipe got rfw=%b exp 0", rfw);
        end
        idle;
    endtask

    task automatic test_flush;
        pipe(5'd1, 32'h1); mc(5'd12, 32'hC); tick;
        mc(5'd13, 32'hD); tick;
        pipe(5'd2, 32'h22); mc(5'd14, 32'hE); flush = 1; #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 2 || wdata !== 32'h22 || mc_ready !== 0) begin
            errors++; $display("FAIL flush_pipe got %b/%0d/%h rdy=%b exp 1/2/22 rdy=0", rfw, rf_waddr, wdata, mc_ready);
        end
        tick; idle; #1;
        checks++;
        if (rfw !== 0 || mc_ready !== 1) begin
            errors++; $display("FAIL flush_empty got rfw=%b a=%0d rdy=%b exp 0 rdy=1", rfw, rf_waddr, mc_ready);
        end
        tick;
        checks++;
        if (rfw !== 0) begin
            errors++; $display("FAIL flush_nopush got rfw=%b a=%0d exp 0", rfw, rf_waddr);
        end
    endtask

    task automatic test_reset_mid;
        pipe(5'd1, 32'h1); mc(5'd15, 32'hF); tick;
        mc(5'd16, 32'h10); tick; idle; #2;
        rst = 1; #1;
        checks++;
        if (rfw !== 0 || mc_ready !== 1 || busy !== 0) begin
            errors++; $display("FAIL midreset_async got rfw=%b rdy=%b busy=%h exp 0/1/0", rfw, mc_ready, busy);
        end
        tick; rst = 0; #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rfw !== 0) begin
                errors++; $display("FAIL midreset_nowrite got rfw=%b a=%0d cyc=%0d exp 0", rfw, rf_waddr, i);
            end
            tick;
        end
    endtask

`ifdef CPU_WB_ARB_SCOREBOARD_EN
    task automatic test_scoreboard;
        mc_issue = 1; mc_issue_addr = 6; tick; mc_issue = 0;
        tick;
        checks++;
        if (busy !== 32'h40) begin
            errors++; $display("FAIL sb_set got %h exp 00000040", busy);
        end
        mc(5'd6, 32'h66); tick; mc_valid = 0; #1;
        checks++;
        if (rfw !== 1 || rf_waddr !== 6 || busy[6] !== 1) begin
            errors++; $display("FAIL sb_write_cycle got rfw=%b a=%0d busy6=%b exp 1/6/1", rfw, rf_waddr, busy[6]);
        end
        tick;
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL sb_clear got %h exp 0", busy);
        end
        mc_issue = 1; mc_issue_addr = 8; mc(5'd8, 32'h88); tick; idle;
        pipe(5'd8, 32'h8); tick; idle;
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL sb_squash got %h exp 0", busy);
        end
        mc_issue = 1; mc_issue_addr = 6; mc(5'd6, 32'h6); tick; idle;
        mc_issue = 1; mc_issue_addr = 6; tick; idle;
        checks++;
        if (busy !== 32'h40) begin
            errors++; $display("FAIL sb_set_wins got %h exp 00000040", busy);
        end
        mc_issue = 1; mc_issue_addr = 20; tick; idle;
        flush = 1; tick; idle;
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL sb_flush got %h exp 0", busy);
        end
    endtask
`else
    task automatic test_busy_off;
        mc_issue = 1; mc_issue_addr = 6; tick; idle; tick;
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL busy_tied got %h exp 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_pipe_priority;
        test_waw;
        test_r0;
        test_flush;
        test_reset_mid;
`ifdef CPU_WB_ARB_SCOREBOARD_EN
        test_scoreboard;
`else
        test_busy_off;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_wb_arb.md
CPU_WB_ARB -- requirements
Module: cpu_wb_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately on rst assertion, independent of clk.
REQ-002 The block SHALL have port `clk` (in, 1): rising-edge clock.
REQ-003 The block SHALL have port `rst` (in, 1): asynchronous reset, active high.
REQ-004 The block SHALL have port `pipe_rfw` (in, 1): the pipeline writeback requests a register write this cycle.
REQ-005 The block SHALL have port `pipe_waddr` (in, 5): the pipeline destination register.
REQ-006 The block SHALL have port `pipe_wdata` (in, 32): the pipeline write data.
REQ-007 The block SHALL have port `mc_valid` (in, 1): the multicycle unit (mul/div) offers a result.
REQ-008 The block SHALL have port `mc_waddr` (in, 5): the multicycle destination register.
REQ-009 The block SHALL have port `mc_wdata` (in, 32): the multicycle result.
REQ-010 The block SHALL have port `mc_ready` (out, 1): the arbiter accepts the multicycle result this cycle.
REQ-011 The block SHALL have port `flush` (in, 1): discard all pending multicycle results.
REQ-012 The block SHALL have port `rfw` (out, 1): register-file write enable.
REQ-013 The block SHALL have port `rf_waddr` (out, 5): register-file write address.
REQ-014 The block SHALL have port `wdata` (out, 32): register-file write data.
REQ-015 The block SHALL have port `mc_issue` (in, 1): a multicycle op is issued this cycle (scoreboard only).
REQ-016 The block SHALL have port `mc_issue_addr` (in, 5): the destination of the issued op.
REQ-017 The block SHALL have port `busy` (out, 32): per-register pending-result bitmap.

Function
REQ-018 The pipeline path SHALL have absolute priority and zero latency: when pipe_rfw=1 and pipe_waddr!=0, then rfw=1, rf_waddr=pipe_waddr and wdata=pipe_wdata combinationally in the same cycle.
REQ-019 Accepted multicycle results SHALL be held in a 2-entry in-order FIFO; each entry SHALL hold {valid, waddr, wdata}.
REQ-020 mc_ready SHALL equal (occupancy<2) && !flush; a push SHALL occur at the clock edge when mc_valid && mc_ready.
REQ-021 When the port is free (no qualifying pipeline write) and the FIFO head is valid, the head SHALL drive rfw=1, rf_waddr and wdata, and SHALL be popped at that edge; the earliest write SHALL occur in the cycle after acceptance, and there SHALL be no same-cycle bypass.
REQ-022 A squashed (invalid) head SHALL be popped in any cycle without driving the port, including cycles in which the pipeline is writing.
REQ-023 A qualifying pipeline write SHALL invalidate every FIFO entry with a matching waddr, including an entry being pushed in the same cycle (WAW: the pipeline write is younger).
REQ-024 Entries and pushes with waddr=0 SHALL be accepted and marked invalid at push; rfw SHALL never assert for address 0.
REQ-025 When neither source writes, rfw=0, rf_waddr=0 and wdata=0.
REQ-026 A simultaneous push and pop SHALL keep occupancy unchanged; occupancy SHALL never exceed 2 or underflow.
REQ-027 flush=1 SHALL empty the FIFO at that edge, block pushes that cycle, and still let a same-cycle pipeline write through.

Reset
REQ-028 During and after reset, the FIFO SHALL be empty, busy=0, mc_ready=1, and the port outputs SHALL follow REQ-018/REQ-025.
REQ-029 Reset asserted mid-operation SHALL discard pending entries without issuing any write.

Configuration
REQ-030 With CPU_WB_ARB_SCOREBOARD_EN defined, busy[n] SHALL set on mc_issue with mc_issue_addr=n (n!=0), and SHALL clear when an entry for n writes, when an entry for n is squashed, or on flush.
REQ-031 With CPU_WB_ARB_SCOREBOARD_EN defined, a same-cycle set and clear of the same bit SHALL resolve to set.
REQ-032 Without CPU_WB_ARB_SCOREBOARD_EN, busy SHALL be tied to 0 and mc_issue and mc_issue_addr SHALL be ignored.

Structure
REQ-033 The shared package SHALL hold the FIFO depth constant (2), the register-address width (5), the data width (32) and the entry record typedef.
REQ-034 The FIFO SHALL be one sub-module, cpu_wb_arb_fifo, with per-entry address-match invalidate.

Verification
REQ-035 Reset then mc push {r5, 0x1234}, pipe idle: the next cycle SHALL show rfw=1, rf_waddr=5 and wdata=0x1234, then the FIFO SHALL be empty.
REQ-036 Two mc pushes r3 and r4 with pipe_rfw=1 to r7 for 3 cycles: mc_ready SHALL be 0 after the second push, and r3 then r4 SHALL write in the 2 cycles after the pipe goes idle.
REQ-037 FIFO holding r9, then pipe writes r9=0xAAAA: r9=0xAAAA SHALL be written and the FIFO entry SHALL be dropped with no second write to r9.
REQ-038 mc push r0 while pipe is idle: rfw SHALL stay 0 throughout and the entry SHALL pop.
REQ-039 FIFO full plus flush, with a pipe write to r2: r2 SHALL be written, the FIFO SHALL be empty next cycle, and mc_ready SHALL return to 1.
REQ-040 With the macro defined, mc_issue r6: busy[6]=1 until the r6 result writes, and 0 the cycle after.
